// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// The rotating-priority search lives here so it can be reused by other arbiters.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set request bit scanning ptr, ptr+1, ... with wrap; returns ptr when req is empty.
  function automatic logic [IDX_W-1:0] next_winner(input logic [N_REQ-1:0] req,
                                                   input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    logic             found;
    next_winner = ptr;
    found       = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        next_winner = cand;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder_2_4 (
  input  logic [1:0] s,
  input  logic       en,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) begin
      y[s] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with a registered owner index and decoded grant.
// Optional hold-time limit with forced revoke is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             tout
);

  if (MAX_HOLD < 1 || MAX_HOLD > (2**CNT_W) - 1) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD out of range for CNT_W");
  end

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             gnt_valid_q;
  logic             tout_q;

  logic [IDX_W-1:0] winner_d;
  logic             owner_drop;
  logic             timeout;
  logic             end_grant;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;

  assign timeout = (state_q == GRANT) && (hold_cnt_q == CNT_W'(MAX_HOLD))
                   && !rel && req[gnt_idx_q];
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    winner_d   = next_winner(req, ptr_q);
    owner_drop = rel || !req[gnt_idx_q];
    end_grant  = owner_drop || timeout;
  end

  // Release and forced revoke share one path: the pointer moves past the owner either way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      tout_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      tout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_idx_q   <= winner_d;
            gnt_valid_q <= 1'b1;
            state_q     <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= CNT_W'(1);
`endif
          end
        end
        GRANT: begin
          if (end_grant) begin
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + IDX_W'(1);
            state_q     <= IDLE;
            tout_q      <= timeout;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt_q != {CNT_W{1'b1}}) begin
              hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  decoder_2_4 u_gnt_dec (
    .s  (gnt_idx_q),
    .en (gnt_valid_q),
    .y  (grant)
  );

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign tout      = tout_q;

endmodule
